eth_hdr_rx_parser: RTL and testbench
====================================

# eth_hdr_rx_parser

Receive-side Ethernet header parser. It sits directly downstream of the MAC-side asynchronous FIFO/width adapter, in the core clock domain, and consumes its 8-bit AXI-Stream frame output. It strips the 14-byte Ethernet II header into a parallel header handshake, filters frames by destination MAC, and forwards the payload as an AXI-Stream to the IP layer.

## Interface
- FILTER_ENABLE, 1: drop frames whose destination MAC is neither `local_mac` nor broadcast.
- ACCEPT_BROADCAST, 1: accept `ff:ff:ff:ff:ff:ff` when filtering.
- clk  in  1  core clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- local_mac  in  48  station MAC; must be quasi-static.
- s_axis_tdata / tvalid / tready / tlast / tuser  in/in/out/in/in  8/1/1/1/1  frame input; tuser=1 on the last beat marks a bad frame.
- m_eth_hdr_valid  out  1  header available.
- m_eth_hdr_ready  in  1  header accepted.
- m_eth_dest_mac, m_eth_src_mac  out  48  first header byte is the MSB.
- m_eth_type  out  16  ethertype, big-endian.
- m_eth_payload_axis_tdata / tvalid / tready / tlast / tuser  out/out/in/out/out  8/1/1/1/1  payload stream.
- busy  out  1  frame in progress (state not IDLE).
- error_header_early_termination  out  1  one-cycle pulse.
- frame_dropped  out  1  one-cycle pulse when a filtered frame's tlast is consumed.

## Operation
FSM states: IDLE, HEADER, PAYLOAD, DROP.

- **IDLE**
  - s_axis_tready = !m_eth_hdr_valid.
  - The first accepted beat is header byte 0; the 4-bit byte counter becomes 1 and the FSM goes to HEADER.
- **HEADER**
  - s_axis_tready = 1.
  - Byte n is shifted into the dest/src/type registers.
  - tlast on a byte with index <13: pulse error_header_early_termination, emit no header, return to IDLE.
  - Byte 13 accepted, filter match, no tlast: set m_eth_hdr_valid and go to PAYLOAD.
  - Byte 13 with tlast and a filter match: set m_eth_hdr_valid, produce no payload beat, go to IDLE.
  - Filter miss: no header. If byte 13 is the last beat, pulse frame_dropped and go to IDLE; otherwise go to DROP.
  - Filter match condition: FILTER_ENABLE=0, or dest==local_mac, or (ACCEPT_BROADCAST && dest==all-ones).
- **PAYLOAD**
  - s_axis_tready = !m_payload_tvalid || m_payload_tready.
  - Each accepted beat is copied to the output register with tdata, tlast and tuser.
  - tlast accepted: go to IDLE.
- **DROP**
  - s_axis_tready = 1; discard all beats.
  - tlast accepted: pulse frame_dropped and go to IDLE.
- **Header register**
  - m_eth_hdr_valid clears on a valid&&ready handshake.
  - Header fields are stable while valid is high.
  - The payload stream flows independently of the header handshake.
- The input tuser in HEADER and DROP states is ignored.

## Timing
- Reset: all outputs 0 (tready, all valids, fields, pulses, busy); state IDLE; counter 0.
- Reset asserted mid-frame: the partial frame is lost. After release the next beat is treated as header byte 0; upstream must re-align on a frame boundary.
- Header latency: m_eth_hdr_valid rises the cycle after the byte-13 handshake.
- Payload latency: one cycle from input accept to m_eth_payload_axis_tvalid.
- Payload throughput: full, one beat per cycle with continuous ready.
- A simultaneous output pop and input accept in PAYLOAD keeps tvalid high with the new beat.
- Back-to-back frames: byte 0 of frame N+1 is accepted on the cycle after frame N's tlast, provided the header of frame N has been consumed.
- m_eth_hdr_valid held with ready=0 blocks only the next frame's byte 0.
- Pulse outputs are high for exactly one cycle per event.
- The byte counter saturates usage at 13 and never wraps inside a frame.
- Output valids do not depend combinationally on ready.
- s_axis_tready depends combinationally on m_eth_payload_axis_tready in PAYLOAD only.

## Structure
- Shared Verilog include `eth_defs.vh`:
  - ETH_HDR_LEN=14
  - ETH_BROADCAST_MAC=48'hffffffffffff
  - FSM state encodings
  - ETHERTYPE_IPV4=16'h0800 and ETHERTYPE_ARP=16'h0806 for downstream users
- The payload output stage is naturally the existing `axis_register` sub-module, configured with 8-bit data, no keep, last and user enabled. The FSM drives its input side.

## Test plan
- 60-byte frame, dest = local_mac 02:00:00:00:00:01, type 0x0800, all readies 1:
  - header fields match the input bytes;
  - 46 payload beats come out with tlast on beat 46;
  - frame_dropped never pulses.
- Same frame with dest 02:00:00:00:00:99 and FILTER_ENABLE=1:
  - no header and no payload beats;
  - exactly one frame_dropped pulse on the tlast cycle.
- Frame with tlast on byte 9:
  - error_header_early_termination pulses once, no header;
  - the following valid 64-byte frame parses correctly.
- Broadcast 64-byte frame with m_eth_hdr_ready held 0 for 100 cycles, then a second frame queued:
  - the first payload completes;
  - byte 0 of frame 2 is stalled until the header handshake, then accepted the next cycle.
- 1500-byte payload with m_eth_payload_axis_tready toggling randomly at 50%:
  - the output byte sequence equals the input;
  - tuser=1 on the input last beat appears on the output last beat.
- rst_n pulsed low at payload byte 20:
  - all outputs read 0 during reset;
  - the next full frame after release parses correctly.

Source files
------------

// File: rtl/eth_hdr_rx_parser_pkg.sv
// Shared constants, FSM state encoding and the destination filter for the
// receive-side Ethernet header parser.
package eth_hdr_rx_parser_pkg;

    localparam int          ETH_HDR_LEN       = 14;
    localparam logic [47:0] ETH_BROADCAST_MAC = 48'hffff_ffff_ffff;
    localparam logic [15:0] ETHERTYPE_IPV4    = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP     = 16'h0806;
    localparam logic [3:0]  HDR_LAST_IDX      = 4'(ETH_HDR_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_e;

    function automatic logic dest_match(input logic [47:0] dest,
                                        input logic [47:0] local_mac,
                                        input logic        filt_en,
                                        input logic        accept_bc);
        return !filt_en || (dest == local_mac) ||
               (accept_bc && (dest == ETH_BROADCAST_MAC));
    endfunction

endpackage

// File: rtl/eth_hdr_rx_parser_if.sv
// Byte-wide AXI-Stream bundle and the parallel Ethernet header handshake.
interface eth_axis_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

interface eth_hdr_if;
    logic        valid;
    logic        ready;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;

    modport master (output valid, dest_mac, src_mac, eth_type, input ready);
    modport slave  (input valid, dest_mac, src_mac, eth_type, output ready);
endinterface

// File: rtl/eth_hdr_rx_parser_axis_register.sv
// Single-entry AXI-Stream output register (8-bit data, last and user, no keep).
module eth_hdr_rx_parser_axis_register
    import eth_hdr_rx_parser_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_tdata,
    input  logic        i_tvalid,
    output logic        o_tready,
    input  logic        i_tlast,
    input  logic        i_tuser,
    eth_axis_if.master  m_axis
);

    logic       r_valid;
    logic [7:0] r_data;
    logic       r_last;
    logic       r_user;

    // A pop and a push in the same cycle keep the stage full with the new beat.
    assign o_tready = !r_valid || m_axis.tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_last  <= 1'b0;
            r_user  <= 1'b0;
        end else begin
            if (i_tvalid && o_tready) begin
                r_valid <= 1'b1;
                r_data  <= i_tdata;
                r_last  <= i_tlast;
                r_user  <= i_tuser;
            end else if (m_axis.tready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign m_axis.tvalid = r_valid;
    assign m_axis.tdata  = r_data;
    assign m_axis.tlast  = r_last;
    assign m_axis.tuser  = r_user;

endmodule

// File: rtl/eth_hdr_rx_parser.sv
// Ethernet II receive parser: strips the 14-byte header into a parallel
// handshake, filters on destination MAC and forwards the payload stream.
module eth_hdr_rx_parser
    import eth_hdr_rx_parser_pkg::*;
#(
    parameter bit FILTER_ENABLE    = 1'b1,
    parameter bit ACCEPT_BROADCAST = 1'b1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] local_mac,
    eth_axis_if.slave   s_axis,
    eth_hdr_if.master   m_eth_hdr,
    eth_axis_if.master  m_eth_payload_axis,
    output logic        busy,
    output logic        error_header_early_termination,
    output logic        frame_dropped
);

    state_e       r_state;
    logic [3:0]   r_cnt;
    logic         r_run;
    logic [111:0] r_hdr;
    logic         r_hdr_valid;
    logic         r_err;
    logic         r_drop;

    logic         w_pl_tready;
    logic         w_pl_tvalid;
    logic         w_s_tready;
    logic         w_accept;
    logic         w_match;
    logic [111:0] w_hdr_shift;

    // r_run keeps tready low while reset is asserted and for one cycle after.
    always_comb begin
        w_s_tready = 1'b0;
        if (r_run) begin
            case (r_state)
                ST_IDLE:            w_s_tready = !r_hdr_valid;
                ST_HEADER, ST_DROP: w_s_tready = 1'b1;
                ST_PAYLOAD:         w_s_tready = w_pl_tready;
                default:            w_s_tready = 1'b0;
            endcase
        end
    end

    assign w_accept    = s_axis.tvalid && w_s_tready;
    assign w_pl_tvalid = s_axis.tvalid && (r_state == ST_PAYLOAD);
    assign w_hdr_shift = {r_hdr[103:0], s_axis.tdata};
    // While byte 13 is on the bus, bytes 0..12 sit in the low 104 bits.
    assign w_match     = dest_match(r_hdr[103:56], local_mac,
                                    FILTER_ENABLE, ACCEPT_BROADCAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_run       <= 1'b0;
            r_hdr       <= '0;
            r_hdr_valid <= 1'b0;
            r_err       <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_run  <= 1'b1;
            r_err  <= 1'b0;
            r_drop <= 1'b0;
            if (r_hdr_valid && m_eth_hdr.ready)
                r_hdr_valid <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        r_hdr <= w_hdr_shift;
                        if (s_axis.tlast) begin
                            r_err <= 1'b1;
                            r_cnt <= 4'd0;
                        end else begin
                            r_cnt   <= 4'd1;
                            r_state <= ST_HEADER;
                        end
                    end
                    ST_HEADER: begin
                        r_hdr <= w_hdr_shift;
                        if (r_cnt == HDR_LAST_IDX) begin
                            if (w_match) begin
                                r_hdr_valid <= 1'b1;
                                r_state     <= s_axis.tlast ? ST_IDLE : ST_PAYLOAD;
                            end else if (s_axis.tlast) begin
                                r_drop  <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_DROP;
                            end
                        end else if (s_axis.tlast) begin
                            r_err   <= 1'b1;
                            r_cnt   <= 4'd0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (s_axis.tlast)
                            r_state <= ST_IDLE;
                    end
                    ST_DROP: begin
                        if (s_axis.tlast) begin
                            r_drop  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    eth_hdr_rx_parser_axis_register u_pl_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_tdata  (s_axis.tdata),
        .i_tvalid (w_pl_tvalid),
        .o_tready (w_pl_tready),
        .i_tlast  (s_axis.tlast),
        .i_tuser  (s_axis.tuser),
        .m_axis   (m_eth_payload_axis)
    );

    assign s_axis.tready      = w_s_tready;
    assign m_eth_hdr.valid    = r_hdr_valid;
    assign m_eth_hdr.dest_mac = r_hdr[111:64];
    assign m_eth_hdr.src_mac  = r_hdr[63:16];
    assign m_eth_hdr.eth_type = r_hdr[15:0];

    assign busy                           = (r_state != ST_IDLE);
    assign error_header_early_termination = r_err;
    assign frame_dropped                  = r_drop;

endmodule

// File: tb/tb_eth_hdr_rx_parser.sv
// Scoreboard bench for eth_hdr_rx_parser: stimulus pushes expected headers and
// payload beats, a monitor pops and compares on every output handshake.
module tb_eth_hdr_rx_parser;
    import eth_hdr_rx_parser_pkg::*;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_99;
    localparam logic [47:0] SRC_MAC   = 48'h00_11_22_33_44_55;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_axis_if #(.DATA_W(8)) s_axis ();
    eth_hdr_if                hdr_if ();
    eth_axis_if #(.DATA_W(8)) pl_if ();
    logic busy, err_pulse, drop_pulse;

    eth_hdr_rx_parser #(.FILTER_ENABLE(1'b1), .ACCEPT_BROADCAST(1'b1)) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .local_mac                      (LOCAL_MAC),
        .s_axis                         (s_axis),
        .m_eth_hdr                      (hdr_if),
        .m_eth_payload_axis             (pl_if),
        .busy                           (busy),
        .error_header_early_termination (err_pulse),
        .frame_dropped                  (drop_pulse)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    int n_hdr = 0, n_pl = 0, n_err = 0, n_drop = 0;
    int exp_nhdr = 0, exp_npl = 0, exp_err = 0, exp_drop = 0;
    bit timed_out = 0;
    bit rand_rdy = 0;
    logic [111:0] exp_hdr_q[$];
    logic [9:0]   exp_pl_q[$];
    int           hs_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        pl_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pl_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: outputs are sampled on the falling edge; a valid&&ready seen
    // here completes on the next rising edge.
    initial begin
        logic [111:0] h;
        logic [9:0]   p;
        forever begin
            @(negedge clk);
            if (hdr_if.valid && hdr_if.ready) begin
                n_hdr++;
                hs_q.push_back(cyc + 1);
                if (exp_hdr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL hdr_unexpected: got %h expected none",
                             {hdr_if.dest_mac, hdr_if.src_mac, hdr_if.eth_type});
                end else begin
                    h = exp_hdr_q.pop_front();
                    chk("hdr_fields", 128'({hdr_if.dest_mac, hdr_if.src_mac, hdr_if.eth_type}), 128'(h));
                end
            end
            if (pl_if.tvalid && pl_if.tready) begin
                n_pl++;
                if (exp_pl_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pl_unexpected: got %h expected none",
                             {pl_if.tuser, pl_if.tlast, pl_if.tdata});
                end else begin
                    p = exp_pl_q.pop_front();
                    chk("pl_beat", 128'({pl_if.tuser, pl_if.tlast, pl_if.tdata}), 128'(p));
                end
            end
            if (err_pulse)  n_err++;
            if (drop_pulse) n_drop++;
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic last, input logic user,
                             output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = -1;
        if (timed_out) return;
        s_axis.tdata  = d;
        s_axis.tvalid = 1'b1;
        s_axis.tlast  = last;
        s_axis.tuser  = user;
        forever begin
            @(negedge clk);
            if (s_axis.tready) break;
            n++;
            if (n > 5000) begin
                checks++; errors++;
                timed_out = 1;
                $display("FAIL input_accept_timeout: got no tready expected accept");
                s_axis.tvalid = 1'b0;
                return;
            end
        end
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] et, input int len,
                              input logic user_last, input logic [7:0] seed,
                              input int abort_at, output int b0_cyc);
        logic [111:0] h;
        logic [7:0]   b;
        logic         lst;
        int           acc;
        h = {dst, SRC_MAC, et};
        b0_cyc = -1;
        if (len < 14) exp_err++;
        else if (!(dst == LOCAL_MAC || dst == ETH_BROADCAST_MAC)) exp_drop++;
        else begin
            exp_hdr_q.push_back(h);
            exp_nhdr++;
            for (int i = 14; i < len; i++) begin
                lst = (i == len - 1);
                exp_pl_q.push_back({lst & user_last, lst, 8'(int'(seed) + i - 14)});
            end
            exp_npl += len - 14;
        end
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) break;
            lst = (i == len - 1);
            b = (i < 14) ? h[111 - 8*i -: 8] : 8'(int'(seed) + i - 14);
            send_beat(b, lst, lst & user_last, acc);
            if (i == 0) b0_cyc = acc;
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tuser  = 1'b0;
    endtask

    task automatic end_test(input string name);
        int n;
        n = 0;
        while ((exp_hdr_q.size() != 0 || exp_pl_q.size() != 0) && n < 6000) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        #1;
        chk({name, "_drained"}, 128'(exp_hdr_q.size() + exp_pl_q.size()), 128'd0);
        chk({name, "_hdr_count"}, 128'(n_hdr), 128'(exp_nhdr));
        chk({name, "_pl_count"}, 128'(n_pl), 128'(exp_npl));
        chk({name, "_err_pulses"}, 128'(n_err), 128'(exp_err));
        chk({name, "_drop_pulses"}, 128'(n_drop), 128'(exp_drop));
        chk({name, "_idle"}, 128'(busy), 128'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, 128'({s_axis.tready, hdr_if.valid, hdr_if.dest_mac, hdr_if.src_mac,
                        hdr_if.eth_type, pl_if.tvalid, pl_if.tdata, pl_if.tlast,
                        pl_if.tuser, busy, err_pulse, drop_pulse}), 128'd0);
    endtask

    initial begin
        int b0, b0_f2;
        s_axis.tdata  = 8'h00;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tuser  = 1'b0;
        hdr_if.ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Unicast 60-byte IPv4 frame to this station.
        send_frame(LOCAL_MAC, ETHERTYPE_IPV4, 60, 1'b0, 8'h00, -1, b0);
        end_test("unicast60");

        // Same frame to a foreign MAC: filtered, one drop pulse.
        send_frame(OTHER_MAC, ETHERTYPE_IPV4, 60, 1'b0, 8'h00, -1, b0);
        end_test("filtered60");

        // tlast on byte 9, then a good 64-byte frame.
        send_frame(LOCAL_MAC, ETHERTYPE_IPV4, 10, 1'b0, 8'h00, -1, b0);
        send_frame(LOCAL_MAC, ETHERTYPE_ARP, 64, 1'b0, 8'h20, -1, b0);
        end_test("early_term");

        // Broadcast frame whose header is held for 100 cycles, frame 2 queued.
        hs_q.delete();
        hdr_if.ready = 1'b0;
        fork
            begin
                int pl_base;
                pl_base = n_pl;
                repeat (100) @(posedge clk);
                #1;
                chk("bcast_payload_while_hdr_held", 128'(n_pl - pl_base), 128'd50);
                chk("bcast_hdr_not_taken_early", 128'(hs_q.size()), 128'd0);
                hdr_if.ready = 1'b1;
            end
            begin
                send_frame(ETH_BROADCAST_MAC, ETHERTYPE_ARP, 64, 1'b0, 8'h40, -1, b0);
                send_frame(LOCAL_MAC, ETHERTYPE_IPV4, 60, 1'b0, 8'h80, -1, b0_f2);
            end
        join
        if (hs_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL b2b_hdr_handshake: got none expected one");
        end else begin
            chk("b2b_byte0_after_hdr_hs", 128'(b0_f2 - hs_q[0]), 128'd1);
        end
        end_test("bcast_stall");

        // 1500-byte payload under random output backpressure, tuser on last.
        rand_rdy = 1'b1;
        send_frame(LOCAL_MAC, ETHERTYPE_IPV4, 1514, 1'b1, 8'h11, -1, b0);
        end_test("jumbo_backpressure");
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted right after payload byte 20 is accepted; byte 19's
        // output slot is wiped, so 19 payload beats emerge.
        send_frame(LOCAL_MAC, ETHERTYPE_IPV4, 50, 1'b0, 8'h90, 34, b0);
        rst_n = 1'b0;
        exp_pl_q.delete();
        exp_npl -= (50 - 14) - 19;
        @(negedge clk);
        chk_reset_outputs("midframe_reset_outputs");
        repeat (2) @(negedge clk);
        chk_reset_outputs("midframe_reset_outputs_held");
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_frame(LOCAL_MAC, ETHERTYPE_ARP, 64, 1'b0, 8'hc0, -1, b0);
        end_test("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
